// File: rtl/poly_note_ctrl.sv
// Polyphonic MIDI note allocator: parses note-on/off messages and assigns notes to NUM_VOICES voices.
// Optional running status via `define POLY_RUNNING_STATUS_EN.
module poly_note_ctrl #(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_WDTH  = 7,
  parameter int AGE_WDTH   = 4,
  parameter int MIDI_CHAN  = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [7:0]                      rx_byte,
  input  logic                            rx_valid,
  output logic                            rx_ready,
  output logic [NUM_VOICES*NOTE_WDTH-1:0] voice_note,
  output logic [NUM_VOICES-1:0]           voice_gate,
  output logic [NUM_VOICES-1:0]           voice_trig,
  output logic                            err_overflow
);

  localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [3:0]          CHAN    = 4'(MIDI_CHAN);
  localparam logic [AGE_WDTH-1:0] AGE_MAX = '1;

  typedef enum logic [1:0] {IDLE, WAIT_NOTE, WAIT_VEL, APPLY} state_t;

  state_t               state_q, state_d;
  logic                 on_q, on_d;
  logic [NOTE_WDTH-1:0] note_lat_q, note_lat_d;
  logic [6:0]           vel_q, vel_d;
`ifdef POLY_RUNNING_STATUS_EN
  logic                 run_q, run_d;
`endif

  logic [NOTE_WDTH-1:0] note_q [NUM_VOICES];
  logic [AGE_WDTH-1:0]  age_q  [NUM_VOICES];
  logic [NUM_VOICES-1:0] gate_q, trig_q;
  logic                 err_q;

  logic accept;
  assign rx_ready = (state_q != APPLY);
  assign accept   = rx_valid && rx_ready;

  always_comb begin
    state_d    = state_q;
    on_d       = on_q;
    note_lat_d = note_lat_q;
    vel_d      = vel_q;
`ifdef POLY_RUNNING_STATUS_EN
    run_d      = run_q;
`endif
    if (accept) begin
      if (rx_byte >= 8'hF8) begin
        state_d = state_q;
      end else if (rx_byte[7]) begin
        if ((rx_byte[7:4] == 4'h9 || rx_byte[7:4] == 4'h8) && rx_byte[3:0] == CHAN) begin
          on_d    = rx_byte[4];
          state_d = WAIT_NOTE;
`ifdef POLY_RUNNING_STATUS_EN
          run_d   = 1'b1;
`endif
        end else begin
          state_d = IDLE;
`ifdef POLY_RUNNING_STATUS_EN
          run_d   = 1'b0;
`endif
        end
      end else begin
        case (state_q)
          WAIT_NOTE: begin
            note_lat_d = NOTE_WDTH'(rx_byte[6:0]);
            state_d    = WAIT_VEL;
          end
          WAIT_VEL: begin
            vel_d   = rx_byte[6:0];
            state_d = APPLY;
          end
          default: begin
`ifdef POLY_RUNNING_STATUS_EN
            // A bare data byte in IDLE reuses the retained note status as a note byte
            if (run_q) begin
              note_lat_d = NOTE_WDTH'(rx_byte[6:0]);
              state_d    = WAIT_VEL;
            end
`endif
          end
        endcase
      end
    end else if (state_q == APPLY) begin
`ifdef POLY_RUNNING_STATUS_EN
      state_d = WAIT_NOTE;
`else
      state_d = IDLE;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      on_q       <= 1'b0;
      note_lat_q <= '0;
      vel_q      <= '0;
`ifdef POLY_RUNNING_STATUS_EN
      run_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      on_q       <= on_d;
      note_lat_q <= note_lat_d;
      vel_q      <= vel_d;
`ifdef POLY_RUNNING_STATUS_EN
      run_q      <= run_d;
`endif
    end
  end

  // Voice selection: existing gated match, else lowest free, else oldest (lowest index on tie)
  logic          note_on, match_found, free_found, steal;
  logic [IW-1:0] match_idx, free_idx, old_idx, chosen_idx;
  logic [AGE_WDTH-1:0] best_age;

  assign note_on = on_q && (vel_q != 7'd0);

  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    old_idx     = '0;
    best_age    = age_q[0];
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (gate_q[i] && note_q[i] == note_lat_q) begin
        match_found = 1'b1;
        match_idx   = IW'(i);
      end
      if (!gate_q[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (age_q[i] > best_age) begin
        best_age = age_q[i];
        old_idx  = IW'(i);
      end
    end
    steal      = !match_found && !free_found;
    chosen_idx = match_found ? match_idx : (free_found ? free_idx : old_idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_q <= '0;
      trig_q <= '0;
      err_q  <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      trig_q <= '0;
      if (state_q == APPLY) begin
        if (note_on && steal) err_q <= 1'b1;
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (note_on) begin
            if (chosen_idx == IW'(i)) begin
              note_q[i] <= note_lat_q;
              gate_q[i] <= 1'b1;
              age_q[i]  <= '0;
              trig_q[i] <= 1'b1;
            end else if (gate_q[i] && age_q[i] != AGE_MAX) begin
              age_q[i] <= age_q[i] + AGE_WDTH'(1);
            end
          end else if (gate_q[i] && note_q[i] == note_lat_q) begin
            gate_q[i] <= 1'b0;
          end
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice_out
      assign voice_note[gi*NOTE_WDTH +: NOTE_WDTH] = note_q[gi];
    end
  endgenerate

  assign voice_gate   = gate_q;
  assign voice_trig   = trig_q;
  assign err_overflow = err_q;

endmodule
